// File: rtl/svn_seg_scan.sv
// 3-digit multiplexed 7-segment driver: double-buffered 12-bit value, BLANK gap before each digit.
// Outputs lag the scan FSM by one cycle; value_rdy_o stays low while the shadow holds data not yet promoted at a frame boundary.
module svn_seg_scan #(
    parameter int   CLK_IN_MHZ   = 125,
    parameter int   REFRESH_HZ   = 1000,
    parameter int   BLANK_CYCLES = 64,
    parameter logic LED_POLARITY = 1'b0,
    parameter logic SEL_POLARITY = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] value_i,
    input  logic [2:0]  dp_i,
    input  logic        value_vld_i,
    output logic        value_rdy_o,
    input  logic        lzs_en_i,
    output logic [7:0]  display_o,
    output logic [2:0]  seg_sel_o,
    output logic        frame_o
);

    localparam int DIGIT_CYC = (CLK_IN_MHZ * 1_000_000) / (REFRESH_HZ * 3);
`ifdef SIM
    localparam bit SIM_TIMING = 1'b1;
`else
    localparam bit SIM_TIMING = 1'b0;
`endif
    localparam int BLANK_C = SIM_TIMING ? 1 : BLANK_CYCLES;
    localparam int SHOW_C  = SIM_TIMING ? 4 : DIGIT_CYC - BLANK_CYCLES;
    localparam int MAX_C   = (BLANK_C > SHOW_C) ? BLANK_C : SHOW_C;
    localparam int TW      = $clog2(MAX_C + 1);

    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_C - 1);
    localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_C - 1);
    localparam logic [7:0]    SEG_OFF    = LED_POLARITY ? 8'h00 : 8'hFF;
    localparam logic [2:0]    SEL_OFF    = SEL_POLARITY ? 3'b000 : 3'b111;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t        state, state_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          boundary;

    logic [11:0]   sh_val, act_val;
    logic [2:0]    sh_dp, act_dp;
    logic          sh_full;

    logic [3:0]    nib;
    logic          dp_bit;
    logic          lz_blank;
    logic [6:0]    seg;
    logic [2:0]    onehot;
    logic [7:0]    display_nxt;
    logic [2:0]    seg_sel_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_BLANK;
            idx   <= 2'd0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        timer_nxt = timer + TW'(1);
        case (state)
            ST_BLANK: begin
                if (timer == BLANK_LAST) begin
                    state_nxt = ST_SHOW;
                    timer_nxt = '0;
                end
            end
            default: begin
                if (timer == SHOW_LAST) begin
                    state_nxt = ST_BLANK;
                    timer_nxt = '0;
                    idx_nxt   = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                end
            end
        endcase
    end

    assign boundary = (state == ST_SHOW) && (idx == 2'd2) && (timer == SHOW_LAST);
    assign frame_o  = boundary;

    // Promotion only at the boundary keeps every frame on a single value; a capture
    // on that same edge lands in the shadow and waits for the next boundary.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_val  <= '0;
            sh_dp   <= '0;
            sh_full <= 1'b0;
            act_val <= '0;
            act_dp  <= '0;
        end else begin
            if (boundary && sh_full) begin
                act_val <= sh_val;
                act_dp  <= sh_dp;
            end
            if (value_vld_i && !sh_full) begin
                sh_val  <= value_i;
                sh_dp   <= dp_i;
                sh_full <= 1'b1;
            end else if (boundary) begin
                sh_full <= 1'b0;
            end
        end
    end

    assign value_rdy_o = ~sh_full;

    always_comb begin
        nib         = act_val[3:0];
        dp_bit      = act_dp[0];
        lz_blank    = 1'b0;
        case (idx)
            2'd0: begin
                nib    = act_val[3:0];
                dp_bit = act_dp[0];
            end
            2'd1: begin
                nib      = act_val[7:4];
                dp_bit   = act_dp[1];
                lz_blank = lzs_en_i && (act_val[11:4] == 8'h00);
            end
            default: begin
                nib      = act_val[11:8];
                dp_bit   = act_dp[2];
                lz_blank = lzs_en_i && (act_val[11:8] == 4'h0);
            end
        endcase
        seg         = lz_blank ? 7'h00 : hex7(nib);
        onehot      = 3'b001 << idx;
        display_nxt = SEG_OFF;
        seg_sel_nxt = SEL_OFF;
        if (state == ST_SHOW) begin
            display_nxt = LED_POLARITY ? {dp_bit, seg} : ~{dp_bit, seg};
            seg_sel_nxt = SEL_POLARITY ? onehot : ~onehot;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            display_o <= SEG_OFF;
            seg_sel_o <= SEL_OFF;
        end else begin
            display_o <= display_nxt;
            seg_sel_o <= seg_sel_nxt;
        end
    end

endmodule
